// File: rtl/tx_buf_arbiter.sv
// tx_buf_arbiter
// Hands the two halves of the TX buffer RAM back and forth between the
// packet decoder (writer) and the USB slave-FIFO engine (reader). Halves are
// filled and sent strictly in alternation, so packets leave in the order they
// were written. One half can fill while the other drains.
//
// Ports:
//   clk, rst_n            ifclk and asynchronous active-low reset
//   i_wr_req              writer wants a half (level)
//   o_wr_grant            1-cycle pulse, o_wr_bank now owned by writer
//   o_wr_bank             write-address MSB
//   i_wr_done, i_wr_len   fill complete pulse and its word count
//   o_rd_start            1-cycle SOP pulse to the slave FIFO
//   o_rd_bank, o_rd_len   read-address MSB and packet word count
//   i_rd_done             packet fully sent pulse
//   o_full, o_empty       no half free / both halves free
//   i_err_clr             clears sticky errors
//   o_proto_err           sticky protocol error
//   o_tmo_err             sticky watchdog error
//
// state   | meaning
// --------+-------------------------------------------------
// H_FREE  | half unowned, may be granted to the writer
// H_FILL  | writer is filling the half
// H_READY | packet complete, waiting for the reader
// H_SEND  | reader is draining the half
// W_IDLE  | writer FSM waiting for a request
// W_FILL  | writer FSM waiting for wr_done
// R_IDLE  | reader FSM waiting for the next READY half
// R_SEND  | reader FSM waiting for rd_done (watchdog running)

module tx_buf_arbiter #(
    parameter int ADDR_NBIT  = 8,
    parameter int TMO_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_wr_req,
    output logic                 o_wr_grant,
    output logic                 o_wr_bank,
    input  logic                 i_wr_done,
    input  logic [ADDR_NBIT:0]   i_wr_len,
    output logic                 o_rd_start,
    output logic                 o_rd_bank,
    output logic [ADDR_NBIT:0]   o_rd_len,
    input  logic                 i_rd_done,
    output logic                 o_full,
    output logic                 o_empty,
    input  logic                 i_err_clr,
    output logic                 o_proto_err,
    output logic                 o_tmo_err
);

    typedef enum logic [1:0] {H_FREE, H_FILL, H_READY, H_SEND} half_t;
    typedef enum logic {W_IDLE, W_FILL} wr_fsm_t;
    typedef enum logic {R_IDLE, R_SEND} rd_fsm_t;

    localparam logic [ADDR_NBIT:0] MAX_LEN = {1'b1, {ADDR_NBIT{1'b0}}};
    localparam int                 WD_W    = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0]    WD_LOAD = WD_W'(TMO_CYCLES);
    localparam bit                 WD_EN   = (TMO_CYCLES != 0);

    half_t              r_half [2];
    half_t              w_half_nxt [2];
    logic [ADDR_NBIT:0] r_len [2];
    wr_fsm_t            r_wr_st;
    rd_fsm_t            r_rd_st;
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic [ADDR_NBIT:0] r_rd_len;
    logic               r_wr_grant;
    logic               r_rd_start;
    logic               r_full;
    logic               r_empty;
    logic               r_proto_err;
    logic               r_tmo_err;
    logic [WD_W-1:0]    r_wdog;

    logic w_grant;
    logic w_len_ok;
    logic w_wr_ok;
    logic w_wr_bad;
    logic w_rd_go;
    logic w_rd_fin;
    logic w_tmo;
    logic w_proto_set;

    always_comb begin
        w_grant  = (r_wr_st == W_IDLE) && i_wr_req && (r_half[r_wr_ptr] == H_FREE);
        w_len_ok = (i_wr_len != '0) && (i_wr_len <= MAX_LEN);
        w_wr_ok  = (r_wr_st == W_FILL) && i_wr_done && w_len_ok;
        w_wr_bad = (r_wr_st == W_FILL) && i_wr_done && !w_len_ok;
        w_rd_go  = (r_rd_st == R_IDLE) && (r_half[r_rd_ptr] == H_READY);
        w_rd_fin = (r_rd_st == R_SEND) && i_rd_done;
        // A rd_done landing on the expiry cycle counts as normal completion.
        w_tmo    = WD_EN && (r_rd_st == R_SEND) && !i_rd_done && (r_wdog == WD_W'(1));
        w_proto_set = w_wr_bad
                    || ((r_wr_st == W_IDLE) && i_wr_done)
                    || ((r_rd_st == R_IDLE) && i_rd_done);

        // The writer only touches FREE/FILL halves and the reader only
        // READY/SEND halves, so these updates never collide on one index.
        w_half_nxt = r_half;
        if (w_grant)            w_half_nxt[r_wr_ptr]  = H_FILL;
        if (w_wr_ok)            w_half_nxt[r_wr_bank] = H_READY;
        if (w_wr_bad)           w_half_nxt[r_wr_bank] = H_FREE;
        if (w_rd_go)            w_half_nxt[r_rd_ptr]  = H_SEND;
        if (w_rd_fin || w_tmo)  w_half_nxt[r_rd_bank] = H_FREE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half[0]   <= H_FREE;
            r_half[1]   <= H_FREE;
            r_len[0]    <= '0;
            r_len[1]    <= '0;
            r_wr_st     <= W_IDLE;
            r_rd_st     <= R_IDLE;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_rd_len    <= '0;
            r_wr_grant  <= 1'b0;
            r_rd_start  <= 1'b0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_proto_err <= 1'b0;
            r_tmo_err   <= 1'b0;
            r_wdog      <= '0;
        end else begin
            r_half     <= w_half_nxt;
            r_full     <= (w_half_nxt[0] != H_FREE) && (w_half_nxt[1] != H_FREE);
            r_empty    <= (w_half_nxt[0] == H_FREE) && (w_half_nxt[1] == H_FREE);
            r_wr_grant <= w_grant;
            r_rd_start <= w_rd_go;

            case (r_wr_st)
                W_IDLE: begin
                    if (w_grant) begin
                        r_wr_bank <= r_wr_ptr;
                        r_wr_ptr  <= ~r_wr_ptr;
                        r_wr_st   <= W_FILL;
                    end
                end
                W_FILL: begin
                    if (w_wr_ok) begin
                        r_len[r_wr_bank] <= i_wr_len;
                        r_wr_st          <= W_IDLE;
                    end else if (w_wr_bad) begin
                        // Abandoned fill: hand the same half out again next.
                        r_wr_ptr <= r_wr_bank;
                        r_wr_st  <= W_IDLE;
                    end
                end
                default: r_wr_st <= W_IDLE;
            endcase

            case (r_rd_st)
                R_IDLE: begin
                    if (w_rd_go) begin
                        r_rd_bank <= r_rd_ptr;
                        r_rd_len  <= r_len[r_rd_ptr];
                        r_wdog    <= WD_LOAD;
                        r_rd_st   <= R_SEND;
                    end
                end
                R_SEND: begin
                    if (w_rd_fin || w_tmo) begin
                        r_rd_ptr <= ~r_rd_ptr;
                        r_rd_st  <= R_IDLE;
                    end else if (WD_EN) begin
                        r_wdog <= r_wdog - WD_W'(1);
                    end
                end
                default: r_rd_st <= R_IDLE;
            endcase

            if (w_proto_set)    r_proto_err <= 1'b1;
            else if (i_err_clr) r_proto_err <= 1'b0;

            if (w_tmo)          r_tmo_err <= 1'b1;
            else if (i_err_clr) r_tmo_err <= 1'b0;
        end
    end

    assign o_wr_grant  = r_wr_grant;
    assign o_wr_bank   = r_wr_bank;
    assign o_rd_start  = r_rd_start;
    assign o_rd_bank   = r_rd_bank;
    assign o_rd_len    = r_rd_len;
    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_proto_err = r_proto_err;
    assign o_tmo_err   = r_tmo_err;

endmodule

// File: doc/tx_buf_arbiter.md
Name: tx_buf_arbiter

Overview:
- Controls ownership of the two halves of the 2×2^ADDR_NBIT-word TX buffer RAM. The half is selected by the address MSB.
- The packet decoder is the writer: it requests a half, fills it and reports the word count. The USB slave-FIFO engine is the reader: it is told which half to send and how long the packet is, then reports completion.
- Both sides run in the same 48 MHz ifclk domain.
- The block enforces strict packet order, lets one half fill while the other drains, and flags protocol errors and stuck transfers.

Parameters:
- ADDR_NBIT, 8, half-buffer address width; a packet holds 1..2^ADDR_NBIT words.
- TMO_CYCLES, 65535, maximum cycles in SEND without rd_done; 0 disables the watchdog.

Ports:
- clk  in  1  ifclk, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_req  in  1  level; writer wants a half to fill
- wr_grant  out  1  one-cycle pulse; half wr_bank now owned by writer
- wr_bank  out  1  half being filled; drives write-address MSB; valid from grant until wr_done
- wr_done  in  1  one-cycle pulse; fill complete
- wr_len  in  ADDR_NBIT+1  word count, sampled with wr_done
- rd_start  out  1  one-cycle pulse to the slave FIFO (packet SOP)
- rd_bank  out  1  half being sent; drives read-address MSB; stable from rd_start until rd_done
- rd_len  out  ADDR_NBIT+1  word count of the packet being sent
- rd_done  in  1  one-cycle pulse; packet fully sent (PKEND issued)
- full  out  1  no half is FREE
- empty  out  1  both halves FREE and no transfer active
- err_clr  in  1  clears sticky errors
- proto_err  out  1  sticky protocol error
- tmo_err  out  1  sticky watchdog error

Behaviour:
- Per-half state: FREE, FILL, READY, SEND. Stored length per half is ADDR_NBIT+1 bits.
- Pointers: wr_ptr, rd_ptr, 1 bit each. Both toggle only as stated below, which guarantees FIFO order.
- Reset (async, rst_n=0):
  - both halves FREE; pointers 0; lengths 0; watchdog 0
  - wr_grant, rd_start, proto_err, tmo_err = 0; wr_bank = rd_bank = 0; rd_len = 0; full = 0; empty = 1
  - a transfer in flight is abandoned with no completion pulse.
- Writer FSM W_IDLE / W_FILL:
  - In W_IDLE, with wr_req=1 and half[wr_ptr] FREE at edge k: half becomes FILL, wr_bank = wr_ptr, wr_ptr toggles, wr_grant is high for cycle k..k+1, FSM goes to W_FILL.
  - In W_FILL, wr_done at edge k with 1 <= wr_len <= 2^ADDR_NBIT: half becomes READY, length stored, FSM goes to W_IDLE.
  - In W_FILL, wr_done with wr_len=0 or wr_len > 2^ADDR_NBIT: half returns to FREE, wr_ptr is restored to that half, proto_err is set, no send.
  - wr_done in W_IDLE: ignored, proto_err set.
  - wr_req while in W_FILL is ignored.
- Reader FSM R_IDLE / R_SEND:
  - In R_IDLE, half[rd_ptr] READY at edge k: half becomes SEND, rd_bank = rd_ptr, rd_len = stored length, rd_start is high for one cycle after edge k, FSM goes to R_SEND, watchdog cleared.
  - In R_SEND, rd_done: half becomes FREE, rd_ptr toggles, FSM goes to R_IDLE.
  - rd_done in R_IDLE: ignored, proto_err set.
  - Watchdog: when TMO_CYCLES != 0 and the watchdog reaches TMO_CYCLES in R_SEND, the half is forced FREE, rd_ptr toggles, FSM goes to R_IDLE, tmo_err is set.
- Latency:
  - wr_req to wr_grant: 1 cycle.
  - wr_done to rd_start: 2 cycles with the reader idle (READY at edge k, rd_start after edge k+1).
  - rd_done to a freed half being grantable: 1 cycle. Decisions use registered state, so a half freed at edge k is grantable at edge k+1 at the earliest.
- Simultaneous events:
  - wr_done and rd_done on different halves in the same cycle are both applied.
  - wr_grant and rd_start may pulse in the same cycle.
  - err_clr has lower priority than a same-cycle error set.
- Flags:
  - full = (neither half FREE).
  - empty = (both FREE).
  - Both are registered, updated with state.

Test Plan:
- Reset, then wr_req=1 -> wr_grant pulses 1 cycle later with wr_bank=0; full=0, empty=0.
- wr_done with wr_len=256 -> rd_start 2 cycles later, rd_bank=0, rd_len=256. Hold wr_req during the send -> grant with wr_bank=1, full=1.
- Fill half 1 (wr_len=10) while half 0 is still SEND; then rd_done -> next rd_start has rd_bank=1, rd_len=10, strictly after half 0; empty=1 after the final rd_done.
- wr_done with wr_len=0, and separately 257 -> proto_err=1, no rd_start, next grant reuses the same bank; err_clr -> proto_err=0.
- TMO_CYCLES=100, withhold rd_done -> after 100 cycles in SEND: tmo_err=1, half FREE, reader idle.
- Assert rst_n low in mid-fill and in mid-send (asynchronously) -> all outputs return to reset values immediately; no rd_start after release until a new fill completes.
